// File: rtl/spram_word_bridge.sv
`timescale 1ns/1ps
// spram_word_bridge
// Upstream request sequencer for a single 16-bit x 16K single-port RAM macro.
// Each 32-bit word request is split into two RAM accesses, low half first,
// then high half. Byte enables become nibble write masks. One response is
// returned per request. After a programmable idle period the RAM is put into
// standby.
//
// Ports:
//   clk, rst_n        clock (also clocks the RAM), async active-low reset
//   req_*             word request: valid/ready, we, addr, wdata, be
//   rsp_*             response: valid/ready, rdata (0 for write responses)
//   ram_addr          halfword address {word_addr, half}
//   ram_datain        RAM write data
//   ram_maskwren      RAM nibble write mask
//   ram_wren, ram_cs  RAM write enable, chip select
//   ram_standby       RAM standby request
//   ram_dataout       RAM read data, valid the cycle after a read access
// All outputs are registered. There is no combinational path from req_* to ram_*.

module spram_word_bridge #(
  parameter int ADDR_W       = 13,
  parameter int STANDBY_IDLE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W:0]   ram_addr,
  output logic [15:0]       ram_datain,
  output logic [3:0]        ram_maskwren,
  output logic              ram_wren,
  output logic              ram_cs,
  output logic              ram_standby,
  input  logic [15:0]       ram_dataout
);

  localparam int CNT_W = (STANDBY_IDLE < 2) ? 1 : $clog2(STANDBY_IDLE + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(STANDBY_IDLE - 1);

  typedef enum logic [2:0] {IDLE, LO, HI, TAIL, RSP, STBY, WAKE} state_t;

  state_t            state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_hi;
  logic [1:0]        be_hi;
  logic [15:0]       rdata_lo;
  logic [CNT_W-1:0]  idle_cnt;

  // The low-half access is loaded straight from the request on the accept edge.
  // Only the high-half fields need to be kept for the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_hi     <= '0;
      be_hi        <= '0;
      rdata_lo     <= '0;
      idle_cnt     <= '0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      ram_addr     <= '0;
      ram_datain   <= '0;
      ram_maskwren <= '0;
      ram_wren     <= 1'b0;
      ram_cs       <= 1'b0;
      ram_standby  <= 1'b0;
    end else begin
      case (state)
        // req_ready is registered, so it is still low in the first cycle
        // after reset. A request is only taken while it is high.
        IDLE: begin
          if (req_ready && req_valid) begin
            we_q         <= req_we;
            addr_q       <= req_addr;
            wdata_hi     <= req_wdata[31:16];
            be_hi        <= req_be[3:2];
            idle_cnt     <= '0;
            req_ready    <= 1'b0;
            ram_cs       <= 1'b1;
            ram_wren     <= req_we;
            ram_addr     <= {req_addr, 1'b0};
            ram_datain   <= req_wdata[15:0];
            ram_maskwren <= req_we ? {req_be[1], req_be[1], req_be[0], req_be[0]} : 4'b0;
            state        <= LO;
          end else if (STANDBY_IDLE != 0 && idle_cnt == IDLE_LAST) begin
            idle_cnt    <= '0;
            req_ready   <= 1'b0;
            ram_standby <= 1'b1;
            state       <= STBY;
          end else begin
            idle_cnt  <= idle_cnt + 1'b1;
            req_ready <= 1'b1;
          end
        end

        LO: begin
          ram_addr     <= {addr_q, 1'b1};
          ram_datain   <= wdata_hi;
          ram_maskwren <= we_q ? {be_hi[1], be_hi[1], be_hi[0], be_hi[0]} : 4'b0;
          state        <= HI;
        end

        // ram_dataout now carries the low half read during LO.
        HI: begin
          ram_cs       <= 1'b0;
          ram_wren     <= 1'b0;
          ram_addr     <= '0;
          ram_datain   <= '0;
          ram_maskwren <= '0;
          if (we_q) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            state     <= RSP;
          end else begin
            rdata_lo <= ram_dataout;
            state    <= TAIL;
          end
        end

        TAIL: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= {ram_dataout, rdata_lo};
          state     <= RSP;
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        // The waking request is left pending. It is accepted in IDLE.
        STBY: begin
          if (req_valid) begin
            ram_standby <= 1'b0;
            state       <= WAKE;
          end
        end

        WAKE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_word_bridge.sv
`timescale 1ns/1ps
// tb_spram_word_bridge
// Self-checking bench for spram_word_bridge. It includes a behavioural model
// of the 16-bit single-port RAM with nibble masks. A table of word
// transactions is applied first. Hand-written sequences follow, covering
// response backpressure, standby entry and exit, and reset in the middle of
// a read.

module tb_spram_word_bridge;

  localparam int ADDR_W       = 13;
  localparam int STANDBY_IDLE = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [3:0]        req_be = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W:0]   ram_addr;
  logic [15:0]       ram_datain;
  logic [3:0]        ram_maskwren;
  logic              ram_wren;
  logic              ram_cs;
  logic              ram_standby;
  logic [15:0]       ram_dataout = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spram_word_bridge #(.ADDR_W(ADDR_W), .STANDBY_IDLE(STANDBY_IDLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_datain(ram_datain), .ram_maskwren(ram_maskwren),
    .ram_wren(ram_wren), .ram_cs(ram_cs), .ram_standby(ram_standby),
    .ram_dataout(ram_dataout)
  );

  // RAM model and a log of every access the bridge makes.
  typedef struct packed {
    logic [13:0] addr;
    logic [15:0] data;
    logic [3:0]  mask;
    logic        wren;
  } acc_t;

  logic [15:0] mem [0:16383];
  acc_t        log_q[$];

  always @(posedge clk) begin
    logic [15:0] bm;
    if (ram_cs) begin
      log_q.push_back(acc_t'{ram_addr, ram_datain, ram_maskwren, ram_wren});
      if (ram_wren) begin
        bm = {{4{ram_maskwren[3]}}, {4{ram_maskwren[2]}}, {4{ram_maskwren[1]}}, {4{ram_maskwren[0]}}};
        mem[ram_addr] <= (mem[ram_addr] & ~bm) | (ram_datain & bm);
      end else begin
        ram_dataout <= mem[ram_addr];
      end
    end
  end

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_mlo;
    logic [3:0]  exp_mhi;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] all_outputs();
    return {25'd0, req_ready, rsp_valid, rsp_rdata, ram_addr, ram_datain,
            ram_maskwren, ram_wren, ram_cs, ram_standby};
  endfunction

  // Presents a request and waits for acceptance. Then waits for rsp_valid.
  // It returns at the negedge where rsp_valid is seen, or when a bound runs out.
  // lat counts the clock edges after the accept edge.
  task automatic apply_stimulus(input logic we, input logic [12:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output int wait_cyc, output int lat);
    log_q.delete();
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    wait_cyc  = 0;
    lat       = 0;
    while (!req_ready && wait_cyc < 40) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!req_ready) begin
      check_output("accept_timeout", 96'd0, 96'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wdata = '0;
    req_be    = '0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   w;
    int   lat;
    logic seen;
    acc_t e;

    for (int a = 0; a < 16384; a++) mem[a] = '0;

    vecs[0] = '{1'b1, 13'h005,  32'hDEADBEEF, 4'hF, 32'h0,        4'hF, 4'hF};
    vecs[1] = '{1'b0, 13'h005,  32'h0,        4'h0, 32'hDEADBEEF, 4'h0, 4'h0};
    vecs[2] = '{1'b1, 13'h005,  32'h11223344, 4'h4, 32'h0,        4'h0, 4'h3};
    vecs[3] = '{1'b0, 13'h005,  32'h0,        4'h0, 32'hDE22BEEF, 4'h0, 4'h0};
    vecs[4] = '{1'b1, 13'h1FFF, 32'hCAFEF00D, 4'h3, 32'h0,        4'hF, 4'h0};
    vecs[5] = '{1'b0, 13'h1FFF, 32'h0,        4'h0, 32'h0000F00D, 4'h0, 4'h0};
    vecs[6] = '{1'b1, 13'h100,  32'hA5A5A5A5, 4'h0, 32'h0,        4'h0, 4'h0};
    vecs[7] = '{1'b0, 13'h100,  32'h0,        4'h0, 32'h0,        4'h0, 4'h0};
    vecs[8] = '{1'b1, 13'h100,  32'h12345678, 4'h9, 32'h0,        4'h3, 4'hC};
    vecs[9] = '{1'b0, 13'h100,  32'h0,        4'h0, 32'h12000078, 4'h0, 4'h0};

    // Reset state, both during reset and at release.
    repeat (3) @(negedge clk);
    check_output("reset_outputs", all_outputs(), 96'd0);
    rst_n = 1'b1;
    #1;
    check_output("release_outputs", all_outputs(), 96'd0);

    // Table-driven transactions.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, w, lat);
      check_output($sformatf("v%0d_latency", i), 96'(lat), vecs[i].we ? 96'd2 : 96'd3);
      check_output($sformatf("v%0d_rdata", i), {64'd0, rsp_rdata}, {64'd0, vecs[i].exp_rdata});
      check_output($sformatf("v%0d_access_count", i), 96'(log_q.size()), 96'd2);
      if (log_q.size() == 2) begin
        e = acc_t'{{vecs[i].addr, 1'b0}, vecs[i].wdata[15:0], vecs[i].exp_mlo, vecs[i].we};
        check_output($sformatf("v%0d_low_access", i), 96'(log_q[0]), 96'(e));
        e = acc_t'{{vecs[i].addr, 1'b1}, vecs[i].wdata[31:16], vecs[i].exp_mhi, vecs[i].we};
        check_output($sformatf("v%0d_high_access", i), 96'(log_q[1]), 96'(e));
      end
      @(negedge clk);
    end

    // Response backpressure: the response holds for 5 cycles with rsp_ready low.
    rsp_ready = 1'b0;
    apply_stimulus(1'b0, 13'h005, 32'h0, 4'h0, w, lat);
    check_output("bp_latency", 96'(lat), 96'd3);
    for (int k = 0; k < 5; k++) begin
      check_output($sformatf("bp_hold%0d", k), {62'd0, rsp_valid, req_ready, rsp_rdata},
                   {62'd0, 1'b1, 1'b0, 32'hDE22BEEF});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_output("bp_release", {94'd0, rsp_valid, req_ready}, {94'd0, 1'b0, 1'b1});

    // Standby: the current cycle is idle cycle 1. Standby is expected in cycle 17.
    seen = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      seen |= ram_standby;
      @(negedge clk);
    end
    check_output("stby_early", {95'd0, seen}, 96'd0);
    check_output("stby_entry", {94'd0, ram_standby, req_ready}, {94'd0, 1'b1, 1'b0});
    req_we    = 1'b0;
    req_addr  = 13'h005;
    req_valid = 1'b1;
    @(negedge clk);
    check_output("wake_cycle", {93'd0, ram_standby, req_ready, ram_cs}, 96'd0);
    @(negedge clk);
    check_output("wake_idle", {94'd0, ram_standby, req_ready}, {94'd0, 1'b0, 1'b1});
    apply_stimulus(1'b0, 13'h005, 32'h0, 4'h0, w, lat);
    check_output("wake_accept_wait", 96'(w), 96'd0);
    check_output("wake_latency", 96'(lat), 96'd3);
    check_output("wake_rdata", {64'd0, rsp_rdata}, {64'd0, 32'hDE22BEEF});
    @(negedge clk);

    // Reset during HI of a read.
    req_we    = 1'b0;
    req_addr  = 13'h005;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_output("midrd_in_hi", {81'd0, ram_cs, ram_addr}, {81'd0, 1'b1, 13'h005, 1'b1});
    rst_n = 1'b0;
    #1;
    check_output("midrd_reset_outputs", all_outputs(), 96'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    check_output("midrd_no_rsp", {95'd0, seen}, 96'd0);
    apply_stimulus(1'b0, 13'h100, 32'h0, 4'h0, w, lat);
    check_output("post_reset_latency", 96'(lat), 96'd3);
    check_output("post_reset_rdata", {64'd0, rsp_rdata}, {64'd0, 32'h12000078});
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spram_word_bridge.md
Name: spram_word_bridge

Overview:
- Upstream request sequencer for one 16-bit x 16K single-port RAM macro.
- Accepts 32-bit word read/write requests with byte enables on a valid/ready interface.
- Splits each request into two 16-bit RAM accesses (low half, then high half) and converts byte enables into nibble write masks.
- Returns one response per request (read data or write acknowledge), and drops the RAM into standby after a programmable idle period.

Parameters:
ADDR_W, 13, word address width; RAM halfword address = {word_addr, half}, 14 bits total
STANDBY_IDLE, 16, consecutive idle cycles before RAM standby; 0 disables standby

Ports:
clk  input  1  system clock; also clocks the RAM
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  bridge accepts request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  32-bit word address
req_wdata  input  32  write data
req_be  input  4  byte enables; bit n covers bits 8n+7:8n
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  32  read data; 0 for write responses
ram_addr  output  14  RAM halfword address
ram_datain  output  16  RAM write data
ram_maskwren  output  4  RAM nibble write mask
ram_wren  output  1  RAM write enable
ram_cs  output  1  RAM chip select
ram_standby  output  1  RAM standby request
ram_dataout  input  16  RAM read data, valid the cycle after a read access

Behaviour:
- Reset state. During rst_n low and after release, all outputs are 0 and the FSM is in IDLE. The idle counter is 0 and the capture registers are 0.
- Top level ties the RAM SLEEP input to 0 and POWEROFF to 1; this block does not drive them.
- Output timing. ram_* outputs come from registered state and captured request only; there is no combinational path from req_* to ram_*.
- FSM states: IDLE, LO, HI, TAIL, RSP, STBY, WAKE.
- IDLE
  - req_ready=1.
  - On req_valid, capture we/addr/wdata/be, clear the idle counter, go to LO.
  - Otherwise increment the idle counter. When it reaches STANDBY_IDLE (and STANDBY_IDLE != 0), go to STBY.
- LO
  - ram_cs=1, ram_addr={addr,1'b0}, ram_wren=we, ram_datain=wdata[15:0].
  - ram_maskwren={be[1],be[1],be[0],be[0]} for writes, 0 for reads.
  - Go to HI.
- HI
  - ram_cs=1, ram_addr={addr,1'b1}, ram_datain=wdata[31:16].
  - ram_maskwren={be[3],be[3],be[2],be[2]} for writes, 0 for reads.
  - Read: register ram_dataout into rdata[15:0], go to TAIL.
  - Write: go to RSP.
- TAIL (reads only)
  - ram_cs=0.
  - Register ram_dataout into rdata[31:16], go to RSP.
- RSP
  - rsp_valid=1. rsp_rdata holds assembled data for reads, 0 for writes; it stays stable while rsp_ready=0.
  - On rsp_ready, go to IDLE.
  - req_ready=0, so at most one request is in flight.
- STBY
  - ram_standby=1, req_ready=0, ram_cs=0.
  - On req_valid, go to WAKE (request not yet accepted).
- WAKE
  - ram_standby=0, req_ready=0, for one cycle. Go to IDLE, where the pending request is accepted.
- Latency (accept edge = E0):
  - Write: rsp_valid rises after E2.
  - Read: rsp_valid rises after E3.
  - From STBY: add 2 cycles (WAKE + IDLE accept).
- Writes with be=0 still perform both accesses with mask 0 and return a response; memory is unchanged.
- Half order is always low then high.
- Address wrap: req_addr all-ones maps to halfwords 0x3FFE and 0x3FFF. No wrap is carried into other words.
- Reset mid-operation aborts the request: no response, RAM outputs return to 0 at once. Contents already written stay written.

Test Plan:
- Full write then read:
  - Stimulus: write addr 0x005, data 0xDEADBEEF, be=0xF; then read 0x005.
  - Required: RAM sees write 0x000A/0xBEEF/mask F, then 0x000B/0xDEAD/mask F.
  - Required: write rsp 2 cycles after accept, rdata 0; read rsp 3 cycles after accept, rdata 0xDEADBEEF.
- Partial write:
  - Stimulus: after the above, write addr 0x005, data 0x11223344, be=0x4; then read.
  - Required: low access mask 0, high access mask 0x3; read returns 0xDE22BEEF.
- Response backpressure:
  - Stimulus: read with rsp_ready=0 for 5 cycles.
  - Required: rsp_valid and rsp_rdata stable all 5 cycles; req_ready=0 until 1 cycle after the rsp_ready handshake.
- Standby entry and exit:
  - Stimulus: STANDBY_IDLE=16, 16 idle cycles, then req_valid read.
  - Required: ram_standby=1 in the 17th cycle; after req_valid, one WAKE cycle; the request is accepted in the following IDLE cycle and returns correct data.
- Address wrap: read req_addr=0x1FFF -> ram_addr sequence 0x3FFE, 0x3FFF.
- Reset mid-read: assert rst_n=0 during HI -> all outputs 0 immediately, no rsp_valid after release, next request completes normally.
